fp_addsub_unpack: RTL and testbench

Front-end operand stage for the FP add/sub datapath in the vector unit. Accepts raw IEEE-754 operand pairs over a valid/ready handshake and classifies each operand as Inf/NaN or denormal/zero. It folds subtraction into B's sign, swaps the operands so that |A| ≥ |B|, and aligns the exponents. Its output is exactly what the add/sub control and mantissa ALU consume (`sa`, `sb`, the per-operand flags, aligned significands and shift amount), delivered through a 2-stage pipeline with full backpressure.

---
 rtl/fp_addsub_unpack.sv | 144 ++++++++++++++
 tb/tb_fp_addsub_unpack.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fp_addsub_unpack.sv
// Operand front end for the FP add/sub datapath: folds subtraction into B's sign,
// orders the operands by magnitude and aligns exponents over a 2-stage pipeline.
module fp_addsub_unpack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic               in_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sa,
    output logic               sb,
    output logic               flag_1_a,
    output logic               flag_1_b,
    output logic               flag_0_a,
    output logic               flag_0_b,
    output logic [MAN_W:0]     man_a,
    output logic [MAN_W:0]     man_b,
    output logic [EXP_W-1:0]   exp_a,
    output logic [EXP_W-1:0]   shift,
    output logic               swapped
);

    localparam logic [EXP_W-1:0] SHIFT_MAX = EXP_W'(MAN_W + 3);
    localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);

    typedef struct packed {
        logic             sign_a;
        logic             sign_b;
        logic [EXP_W-1:0] exp_a;
        logic [EXP_W-1:0] exp_b;
        logic [MAN_W-1:0] man_a;
        logic [MAN_W-1:0] man_b;
        logic             inf_a;
        logic             inf_b;
        logic             den_a;
        logic             den_b;
        logic             swap;
    } s1_t;

    typedef struct packed {
        logic             sa;
        logic             sb;
        logic             f1a;
        logic             f1b;
        logic             f0a;
        logic             f0b;
        logic [MAN_W:0]   man_a;
        logic [MAN_W:0]   man_b;
        logic [EXP_W-1:0] exp_a;
        logic [EXP_W-1:0] shift;
        logic             swapped;
    } s2_t;

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    s1_t              s1_q, s1_d;
    s2_t              s2_q, s2_d;
    logic             s1_adv, s2_adv;
    logic [EXP_W-1:0] hi_exp, lo_exp, hi_eff, lo_eff, diff;
    logic [MAN_W-1:0] hi_man, lo_man;

    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;

        // NOTE: every always_comb output is defaulted first so no path can infer a latch.
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s1_d       = s1_q;
        if (in_valid && s1_adv) begin
            s1_d.sign_a = in_a[EXP_W+MAN_W];
            s1_d.sign_b = in_b[EXP_W+MAN_W] ^ in_sub;
            s1_d.exp_a  = in_a[MAN_W +: EXP_W];
            s1_d.exp_b  = in_b[MAN_W +: EXP_W];
            s1_d.man_a  = in_a[MAN_W-1:0];
            s1_d.man_b  = in_b[MAN_W-1:0];
            s1_d.inf_a  = &in_a[MAN_W +: EXP_W];
            s1_d.inf_b  = &in_b[MAN_W +: EXP_W];
            s1_d.den_a  = ~|in_a[MAN_W +: EXP_W];
            s1_d.den_b  = ~|in_b[MAN_W +: EXP_W];
            // Equal magnitudes keep the original order.
            s1_d.swap   = in_a[EXP_W+MAN_W-1:0] < in_b[EXP_W+MAN_W-1:0];
        end

        hi_exp = s1_q.swap ? s1_q.exp_b : s1_q.exp_a;
        lo_exp = s1_q.swap ? s1_q.exp_a : s1_q.exp_b;
        hi_man = s1_q.swap ? s1_q.man_b : s1_q.man_a;
        lo_man = s1_q.swap ? s1_q.man_a : s1_q.man_b;
        hi_eff = (hi_exp == '0) ? EXP_ONE : hi_exp;
        lo_eff = (lo_exp == '0) ? EXP_ONE : lo_exp;
        diff   = hi_eff - lo_eff;

        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_d       = s2_q;
        if (s2_adv && s1_valid_q) begin
            s2_d.sa      = s1_q.swap ? s1_q.sign_b : s1_q.sign_a;
            s2_d.sb      = s1_q.swap ? s1_q.sign_a : s1_q.sign_b;
            s2_d.f1a     = s1_q.swap ? s1_q.inf_b  : s1_q.inf_a;
            s2_d.f1b     = s1_q.swap ? s1_q.inf_a  : s1_q.inf_b;
            s2_d.f0a     = s1_q.swap ? s1_q.den_b  : s1_q.den_a;
            s2_d.f0b     = s1_q.swap ? s1_q.den_a  : s1_q.den_b;
            s2_d.man_a   = {hi_exp != '0, hi_man};
            s2_d.man_b   = {lo_exp != '0, lo_man};
            s2_d.exp_a   = hi_eff;
            s2_d.shift   = (diff > SHIFT_MAX) ? SHIFT_MAX : diff;
            s2_d.swapped = s1_q.swap;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign sa        = s2_q.sa;
    assign sb        = s2_q.sb;
    assign flag_1_a  = s2_q.f1a;
    assign flag_1_b  = s2_q.f1b;
    assign flag_0_a  = s2_q.f0a;
    assign flag_0_b  = s2_q.f0b;
    assign man_a     = s2_q.man_a;
    assign man_b     = s2_q.man_b;
    assign exp_a     = s2_q.exp_a;
    assign shift     = s2_q.shift;
    assign swapped   = s2_q.swapped;

endmodule

// File: tb/tb_fp_addsub_unpack.sv
// Directed bench for fp_addsub_unpack: single-pair vectors, backpressure streaming
// and mid-stream reset, all against hand-computed expectations.
module tb_fp_addsub_unpack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sub;
    logic [31:0] in_a, in_b;
    logic        out_valid, out_ready;
    logic        sa, sb, flag_1_a, flag_1_b, flag_0_a, flag_0_b, swapped;
    logic [23:0] man_a, man_b;
    logic [7:0]  exp_a, shift;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_addsub_unpack #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sa(sa), .sb(sb), .flag_1_a(flag_1_a), .flag_1_b(flag_1_b),
        .flag_0_a(flag_0_a), .flag_0_b(flag_0_b),
        .man_a(man_a), .man_b(man_b), .exp_a(exp_a), .shift(shift),
        .swapped(swapped)
    );

    logic [70:0] obs;
    assign obs = {sa, sb, flag_1_a, flag_1_b, flag_0_a, flag_0_b, swapped,
                  exp_a, shift, man_a, man_b};

    function automatic logic [70:0] mk(input logic xsa, xsb, f1a, f1b, f0a, f0b, sw,
                                       input logic [7:0] ea, sh,
                                       input logic [23:0] ma, mb);
        return {xsa, xsb, f1a, f1b, f0a, f0b, sw, ea, sh, ma, mb};
    endfunction

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // One pair in, expect nothing after one cycle and the result after two.
    task automatic run_one(input string tag, input logic [31:0] a, b, input logic sub,
                           input logic [70:0] want);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; out_ready = 1'b1;
        #1 check({tag, "_rdy"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({tag, "_lat1"}, out_valid, 0);
        @(negedge clk);
        #1 check({tag, "_vld"}, out_valid, 1);
        check(tag, obs, want);
    endtask

    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic        ps [4];
    logic [70:0] pe [4];

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, recv, last_cyc, accepted;
        logic fire_in, fire_out;

        pa[0] = 32'h3F800000; pb[0] = 32'h40000000; ps[0] = 1'b0;
        pe[0] = mk(0, 0, 0, 0, 0, 0, 1, 8'h80, 8'd1, 24'h800000, 24'h800000);
        pa[1] = 32'h40400000; pb[1] = 32'h40400000; ps[1] = 1'b1;
        pe[1] = mk(0, 1, 0, 0, 0, 0, 0, 8'h80, 8'd0, 24'hC00000, 24'hC00000);
        pa[2] = 32'h40A00000; pb[2] = 32'h3F000000; ps[2] = 1'b0;
        pe[2] = mk(0, 0, 0, 0, 0, 0, 0, 8'h81, 8'd3, 24'hA00000, 24'h800000);
        pa[3] = 32'hC0000000; pb[3] = 32'h40800000; ps[3] = 1'b1;
        pe[3] = mk(1, 1, 0, 0, 0, 0, 1, 8'h81, 8'd1, 24'h800000, 24'h800000);

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check("rst_vld", out_valid, 0);
        check("rst_data", obs, 0);
        check("rst_rdy", in_ready, 1);

        run_one("add", pa[0], pb[0], 1'b0, pe[0]);
        run_one("sub", pa[0], pb[0], 1'b1,
                mk(1, 0, 0, 0, 0, 0, 1, 8'h80, 8'd1, 24'h800000, 24'h800000));
        run_one("eq_sub", pa[1], pb[1], 1'b1, pe[1]);
        run_one("inf_den", 32'h7F800000, 32'h00000001, 1'b0,
                mk(0, 0, 1, 0, 0, 1, 0, 8'hFF, 8'd26, 24'h800000, 24'h000001));
        run_one("nan_swap", 32'h00000000, 32'h7FC00000, 1'b0,
                mk(0, 0, 1, 0, 0, 1, 1, 8'hFF, 8'd26, 24'hC00000, 24'h000000));

        // Backpressure: out_ready low, offer all four pairs continuously.
        sent = 0; accepted = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            in_valid = 1'b1; in_a = pa[sent]; in_b = pb[sent]; in_sub = ps[sent];
            #1 fire_in = in_valid && in_ready;
            @(posedge clk);
            if (fire_in) begin accepted++; sent++; end
        end
        check("bp_accepted", accepted, 2);
        @(negedge clk);
        #1 check("bp_stall_rdy", in_ready, 0);
        check("bp_head_held", obs, pe[0]);

        // Release: remaining pairs stream in while results drain one per cycle.
        recv = 0; last_cyc = 0;
        for (int c = 0; c < 20 && recv < 4; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid = (sent < 4);
            if (sent < 4) begin in_a = pa[sent]; in_b = pb[sent]; in_sub = ps[sent]; end
            #1 fire_in = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                check($sformatf("bp_out%0d", recv), obs, pe[recv]);
                if (recv > 0) check($sformatf("bp_gap%0d", recv), c - last_cyc, 1);
                last_cyc = c;
                recv++;
            end
            @(posedge clk);
            if (fire_in) sent++;
        end
        check("bp_recv", recv, 4);

        // Reset with two pairs in flight.
        @(negedge clk);
        in_valid = 1'b1; in_a = pa[0]; in_b = pb[0]; in_sub = ps[0]; out_ready = 1'b0;
        @(negedge clk);
        in_a = pa[3]; in_b = pb[3]; in_sub = ps[3];
        @(negedge clk);
        #1 check("mid_pre_vld", out_valid, 1);
        rst = 1'b1; in_a = pa[2]; in_b = pb[2]; in_sub = ps[2];
        @(negedge clk);
        #1 check("mid_rst_vld", out_valid, 0);
        check("mid_rst_data", obs, 0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #1 check("mid_flushed", out_valid, 0);
        run_one("post_rst", pa[2], pb[2], ps[2], pe[2]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
